ro_sense_counter: RTL



---
 rtl/ro_sense_counter.sv | 137 +++++++++++++
 1 files changed

// File: rtl/ro_sense_counter.sv
// Multi-channel ring-oscillator edge counter for the thermal sensor array.
// Each channel synchronises its oscillator and counts rising edges over a latched window of clk cycles.

module ro_sense_ch #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ro_i,
  input  logic             clr_i,
  input  logic             cnt_en_i,
  output logic [CNT_W-1:0] acc_d_o,
  output logic             sat_d_o
);
  // sync_q[0]=s1, sync_q[1]=s2, sync_q[2]=history s3
  logic [2:0]       sync_q;
  logic [CNT_W-1:0] acc_q;
  logic             sat_q;
  logic             rise;

  assign rise = sync_q[1] & ~sync_q[2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      acc_q  <= '0;
      sat_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], ro_i};
      acc_q  <= acc_d_o;
      sat_q  <= sat_d_o;
    end
  end

  always_comb begin
    acc_d_o = acc_q;
    sat_d_o = sat_q;
    if (clr_i) begin
      acc_d_o = '0;
      sat_d_o = 1'b0;
    end else if (cnt_en_i && rise) begin
      if (&acc_q) sat_d_o = 1'b1;
      else        acc_d_o = acc_q + 1'b1;
    end
  end
endmodule

module ro_sense_counter #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16,
  parameter int WIN_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       ro_in,
  input  logic [NUM_CH-1:0]       ch_en,
  input  logic                    start,
  input  logic [WIN_W-1:0]        window,
  output logic                    busy,
  output logic                    done,
  output logic                    count_valid,
  output logic [NUM_CH*CNT_W-1:0] count_out,
  output logic [NUM_CH-1:0]       overflow
);
  typedef enum logic [1:0] {S_IDLE, S_COUNT, S_DONE} state_t;

  state_t                         state_q, state_d;
  logic [WIN_W-1:0]               rem_q;
  logic [NUM_CH-1:0]              en_q;
  logic [NUM_CH-1:0][CNT_W-1:0]   acc_d;
  logic [NUM_CH-1:0]              sat_d;
  logic [NUM_CH-1:0][CNT_W-1:0]   count_out_q;
  logic [NUM_CH-1:0]              overflow_q;
  logic                           count_valid_q;
  logic                           accept, load;

  assign accept = (state_q == S_IDLE) && start;
  // A window==0 start clears the accumulators in the same cycle, so acc_d is already zero here.
  assign load   = (state_d == S_DONE) && (state_q != S_DONE);

  genvar i;
  generate
    for (i = 0; i < NUM_CH; i++) begin : g_ch
      ro_sense_ch #(.CNT_W(CNT_W)) u_ch (
        .clk      (clk),
        .rst      (rst),
        .ro_i     (ro_in[i]),
        .clr_i    (accept),
        .cnt_en_i ((state_q == S_COUNT) && en_q[i]),
        .acc_d_o  (acc_d[i]),
        .sat_d_o  (sat_d[i])
      );
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = (window == '0) ? S_DONE : S_COUNT;
      S_COUNT: if (rem_q == WIN_W'(1)) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      rem_q         <= '0;
      en_q          <= '0;
      count_out_q   <= '0;
      overflow_q    <= '0;
      count_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        rem_q <= window;
        en_q  <= ch_en;
      end else if (state_q == S_COUNT) begin
        rem_q <= rem_q - 1'b1;
      end
      if (load) begin
        count_out_q   <= acc_d;
        overflow_q    <= sat_d;
        count_valid_q <= 1'b1;
      end else if (accept) begin
        count_valid_q <= 1'b0;
      end
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign count_valid = count_valid_q;
  assign count_out   = count_out_q;
  assign overflow    = overflow_q;
endmodule
